// File: rtl/alu_op_issuer.sv
// Issues requests to a registered ALU, tracks them through its fixed latency and
// returns results in order through a credit-limited first-word fall-through FIFO.
module alu_op_issuer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OPW     = 3,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OPW-1:0]   req_op,
  input  logic [TAGW-1:0]  req_tag,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   Op,
  input  logic [WIDTH-1:0] R,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic [TAGW-1:0]  rsp_tag,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      done_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DepthSum = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic             accept, capture, pop;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_r_q   [DEPTH];
  logic [TAGW-1:0]  mem_tag_q [DEPTH];
  logic [ALU_LAT:0] pipe_vld_q;
  logic [TAGW-1:0]  pipe_tag_q [ALU_LAT+1];
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic [15:0]      issued_q, done_q;

  // Credit counts both in-flight and buffered results, so a pop only frees a slot
  // once fifo_cnt_q has been updated on the following edge.
  always_comb begin
    req_ready  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DepthSum;
    accept     = req_valid && req_ready;
    capture    = pipe_vld_q[ALU_LAT];
    rsp_valid  = fifo_cnt_q != '0;
    pop        = rsp_valid && rsp_ready;
    inflight_d = inflight_q + CW'(accept) - CW'(capture);
    fifo_cnt_d = fifo_cnt_q + CW'(capture) - CW'(pop);
  end

  assign A          = a_q;
  assign B          = b_q;
  assign Op         = op_q;
  assign rsp_r      = mem_r_q[rd_ptr_q];
  assign rsp_tag    = mem_tag_q[rd_ptr_q];
  assign issued_cnt = issued_q;
  assign done_cnt   = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      issued_q   <= '0;
      done_q     <= '0;
    end else begin
      if (accept) begin
        a_q      <= req_a;
        b_q      <= req_b;
        op_q     <= req_op;
        issued_q <= issued_q + 16'd1;
      end
      if (pop) begin
        done_q <= done_q + 16'd1;
      end
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Stage i holds the request whose operands have been on the ALU for i cycles;
  // the last stage lines up with R for that request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i <= ALU_LAT; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q    <= {pipe_vld_q[ALU_LAT-1:0], accept};
      pipe_tag_q[0] <= req_tag;
      for (int unsigned i = 1; i <= ALU_LAT; i++) begin
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r_q[i]   <= '0;
        mem_tag_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        mem_r_q[wr_ptr_q]   <= R;
        mem_tag_q[wr_ptr_q] <= pipe_tag_q[ALU_LAT];
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(capture && (fifo_cnt_q == DepthCnt)));

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: registered ALU model, queue-based reference of
// outstanding responses, directed vector table and randomized traffic.
module tb_alu_op_issuer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned OPW     = 3;
  localparam int unsigned TAGW    = 4;
  localparam int unsigned ALU_LAT = 1;
  localparam int unsigned DEPTH   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic [OPW-1:0]   req_op;
  logic [TAGW-1:0]  req_tag;
  logic [WIDTH-1:0] A, B, R;
  logic [OPW-1:0]   Op;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_r;
  logic [TAGW-1:0]  rsp_tag;
  logic [15:0]      issued_cnt, done_cnt;

  alu_op_issuer #(
    .WIDTH(WIDTH), .OPW(OPW), .TAGW(TAGW), .ALU_LAT(ALU_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .A(A), .B(B), .Op(Op), .R(R),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_tag(rsp_tag),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return 8'(a + b);
      3'd1:    return 8'(a - b);
      3'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Registered ALU with one cycle of latency.
  always @(posedge clk) R <= alu_fn(A, B, Op);

  typedef struct {
    logic [7:0] r;
    logic [3:0] tag;
    int         ready_edge;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] tag;
    logic [7:0] r;
  } vec_t;

  exp_t        exp_q[$];
  int          edge_cnt;
  int          m_out;
  logic [15:0] m_issued, m_done;
  logic [7:0]  pop_r[$];
  logic [3:0]  pop_tag[$];
  int          pop_edge[$];
  int          n_checks, n_errors;
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out    = 0;
    m_issued = '0;
    m_done   = '0;
  endtask

  task automatic chk_reset(input string name);
    chk({name, " A"}, 32'(A), 0);
    chk({name, " B"}, 32'(B), 0);
    chk({name, " Op"}, 32'(Op), 0);
    chk({name, " req_ready"}, 32'(req_ready), 1);
    chk({name, " rsp_valid"}, 32'(rsp_valid), 0);
    chk({name, " rsp_r"}, 32'(rsp_r), 0);
    chk({name, " rsp_tag"}, 32'(rsp_tag), 0);
    chk({name, " issued_cnt"}, 32'(issued_cnt), 0);
    chk({name, " done_cnt"}, 32'(done_cnt), 0);
  endtask

  // Called at a falling edge with inputs already driven: checks outputs against
  // the model, lets one rising edge pass, updates the model, returns at the next
  // falling edge.
  task automatic cycle();
    logic acc, pop, exp_rdy, exp_vld;
    logic [7:0] cur_r;
    logic [3:0] cur_tag;
    exp_rdy = m_out < DEPTH;
    exp_vld = (exp_q.size() > 0) && (exp_q[0].ready_edge <= edge_cnt);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (exp_vld && rsp_valid) begin
      chk("rsp_r", 32'(rsp_r), 32'(exp_q[0].r));
      chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
    end
    chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
    chk("done_cnt", 32'(done_cnt), 32'(m_done));
    acc     = req_valid && req_ready;
    pop     = rsp_valid && rsp_ready;
    cur_r   = rsp_r;
    cur_tag = rsp_tag;
    @(posedge clk);
    edge_cnt++;
    if (pop && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_done++;
      m_out--;
      pop_r.push_back(cur_r);
      pop_tag.push_back(cur_tag);
      pop_edge.push_back(edge_cnt);
    end
    if (acc) begin
      exp_q.push_back('{r: alu_fn(req_a, req_b, req_op), tag: req_tag,
                        ready_edge: edge_cnt + 1 + ALU_LAT});
      m_issued++;
      m_out++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [3:0] tag);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    cycle();
  endtask

  initial begin
    int n_acc;
    n_checks = 0;
    n_errors = 0;
    edge_cnt = 0;
    model_reset();
    vecs[0] = '{a: 8'h12, b: 8'h34, op: 3'd0, tag: 4'd5, r: 8'h46};
    vecs[1] = '{a: 8'hFF, b: 8'h02, op: 3'd0, tag: 4'd1, r: 8'h01};
    vecs[2] = '{a: 8'h00, b: 8'h01, op: 3'd1, tag: 4'd2, r: 8'hFF};
    vecs[3] = '{a: 8'h80, b: 8'h80, op: 3'd0, tag: 4'd3, r: 8'h00};
    vecs[4] = '{a: 8'h05, b: 8'h07, op: 3'd1, tag: 4'hE, r: 8'hFE};

    reset     = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    reset = 1'b1;
    cycle();

    // Directed vectors: one request each, response checked against the table.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
      rsp_ready = 1'b0;
      cycle();
      req_valid = 1'b0;
      chk("vec rsp_valid k", 32'(rsp_valid), 0);
      cycle();
      chk("vec A", 32'(A), 32'(vecs[i].a));
      chk("vec B", 32'(B), 32'(vecs[i].b));
      chk("vec Op", 32'(Op), 32'(vecs[i].op));
      chk("vec rsp_valid k+1", 32'(rsp_valid), 0);
      cycle();
      chk("vec rsp_valid k+2", 32'(rsp_valid), 1);
      chk("vec rsp_r", 32'(rsp_r), 32'(vecs[i].r));
      chk("vec rsp_tag", 32'(rsp_tag), 32'(vecs[i].tag));
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      chk("vec issued_cnt", 32'(issued_cnt), 32'(i + 1));
      chk("vec done_cnt", 32'(done_cnt), 32'(i + 1));
      chk("vec rsp_valid after pop", 32'(rsp_valid), 0);
    end

    // Back-to-back: full throughput, responses on consecutive cycles.
    pop_r.delete();
    pop_tag.delete();
    pop_edge.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 8'h01, 3'd0, 4'(i));
      chk("b2b req_ready", 32'(req_ready), 1);
      cycle();
    end
    drain();
    chk("b2b pop count", 32'(pop_r.size()), 8);
    for (int j = 0; j < 8 && j < pop_r.size(); j++) begin
      chk("b2b tag", 32'(pop_tag[j]), 32'(j));
      chk("b2b r", 32'(pop_r[j]), 32'(j + 1));
      chk("b2b consecutive", 32'(pop_edge[j]), 32'(pop_edge[0] + j));
    end

    // Backpressure: exactly DEPTH accepts, then one pop frees one slot.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 3)), 4'(i));
      if (req_ready) n_acc++;
      cycle();
    end
    chk("bp accepts", 32'(n_acc), DEPTH);
    chk("bp req_ready low", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk("bp req_ready after pop", 32'(req_ready), 1);
    cycle();
    chk("bp req_ready full again", 32'(req_ready), 0);
    drain();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 3)), 4'($urandom));
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    // Reset while results are in flight and buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i + 3), 8'h10, 3'd0, 4'(i + 8));
      cycle();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset("rst async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst held");
    model_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    pop_r.delete();
    drive(1'b1, 8'h09, 8'h03, 3'd1, 4'd7);
    cycle();
    drain();
    chk("rst issued_cnt", 32'(issued_cnt), 1);
    chk("rst pop count", 32'(pop_r.size()), 1);
    if (pop_r.size() > 0) chk("rst rsp_r", 32'(pop_r[0]), 32'h06);

    // issued_cnt wrap from 0xFFFF.
    force dut.issued_q = 16'hFFFF;
    #1;
    release dut.issued_q;
    m_issued = 16'hFFFF;
    drive(1'b1, 8'h01, 8'h01, 3'd0, 4'd3);
    cycle();
    req_valid = 1'b0;
    chk("issued wrap", 32'(issued_cnt), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
